// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
// AHB-Lite signal bundle between one master port and ahb_sram_slave.
//
// Handshake: an address phase is offered by the master (hsel & htrans[1]) and
// is taken only at a rising edge where hready=1. A data phase ends at the
// rising edge where hreadyout=1; hwdata/hrdata/hresp belong to that phase.
//
// Signals
//   hsel, haddr[31:0], htrans[1:0], hwrite, hsize[2:0], hburst[2:0],
//   hprot[3:0], hmastlock, hwdata[31:0], hready   master -> slave
//   hreadyout, hresp, hrdata[31:0]                slave  -> master
// Modports: master, slave
// ---------------------------------------------------------------------------
interface ahb_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
           hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
           hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite responder with a word-organised SRAM. Supports pipelined
// back-to-back transfers, byte/halfword/word writes, and answers out-of-range,
// misaligned or oversized accesses with the two-cycle ERROR response.
//
// Optional feature macro: AHB_SLV_WAITSTATE_EN
//   defined   -> WAIT_CYCLES wait states inserted in every OKAY data phase
//   undefined -> zero-wait OKAY, WAIT_CYCLES ignored
//
// Parameters
//   MEM_BYTES    SRAM size in bytes (power of 2, >= 4)
//   WAIT_CYCLES  wait states per OKAY transfer (0..15), macro builds only
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   bus          ahb_sram_slave_if.slave bus bundle
//   o_dbg_state  current FSM state (0=IDLE 1=DATA 2=ERR1 3=ERR2)
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  ahb_sram_slave_if.slave        bus,
  output logic [1:0]             o_dbg_state
);

  localparam int AW = $clog2(MEM_BYTES);
  // Word index width; a 4-byte memory still gets a 1-bit index (only entry 0
  // is ever addressed) so the array never collapses to zero width.
  localparam int IW    = (AW > 2) ? AW - 2 : 1;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_addr;
  logic [1:0]      r_size;
  logic            r_write;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_err;
  logic            w_open;
  logic            w_take;
  logic            w_wait_zero;
  logic            w_data_last;
  logic            w_we;
  logic [3:0]      w_be;
  logic [IW-1:0]   w_idx;
  logic            w_unused_ok;

  assign w_accept = bus.hsel & bus.htrans[1] & bus.hready;

  assign w_err = (bus.haddr >= 32'(MEM_BYTES))
               | (bus.hsize > 3'd2)
               | ((bus.hsize == 3'd1) & bus.haddr[0])
               | ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'b00));

  // A new address phase can only be taken where our own data phase is
  // finishing (or there is none); this keeps the registered address stable
  // even if a shared hready says otherwise.
  assign w_data_last = (r_state == S_DATA) & w_wait_zero;
  assign w_open      = (r_state == S_IDLE) | w_data_last | (r_state == S_ERR2);
  assign w_take      = w_accept & w_open;

  assign w_idx = IW'(r_addr >> 2);
  assign w_we  = w_data_last & r_write;

  // Little-endian byte lanes from the registered address and size.
  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_addr[1:0];
      2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

`ifdef AHB_SLV_WAITSTATE_EN
  logic [3:0] r_wait_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wait_cnt <= 4'd0;
    end else if (w_take & ~w_err) begin
      r_wait_cnt <= 4'(WAIT_CYCLES);
    end else if ((r_state == S_DATA) && (r_wait_cnt != 4'd0)) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  assign w_wait_zero = (r_wait_cnt == 4'd0);
  assign w_unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};
`else
  assign w_wait_zero = 1'b1;
  assign w_unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0],
                         32'(WAIT_CYCLES)};
`endif

  // Address-phase capture. The error flag is carried by the FSM state, so
  // addr/size/write only matter for transfers that reach DATA.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr  <= '0;
      r_size  <= 2'd0;
      r_write <= 1'b0;
    end else if (w_take) begin
      r_addr  <= bus.haddr[AW-1:0];
      r_size  <= bus.hsize[1:0];
      r_write <= bus.hwrite;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_take) w_next = w_err ? S_ERR1 : S_DATA;
      end
      S_DATA: begin
        bus.hreadyout = w_wait_zero;
        if (w_wait_zero && !r_write) bus.hrdata = r_mem[w_idx];
        if (w_wait_zero) begin
          if (w_take) w_next = w_err ? S_ERR1 : S_DATA;
          else        w_next = S_IDLE;
        end
      end
      S_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
        w_next        = S_ERR2;
      end
      S_ERR2: begin
        bus.hresp = 1'b1;
        if (w_take) w_next = w_err ? S_ERR1 : S_DATA;
        else        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // SRAM is not reset. Reset forces the FSM to IDLE, so a write whose data
  // phase was cut short never commits.
  always_ff @(posedge CLK) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
// Directed bench for ahb_sram_slave: word/byte/halfword writes, reads,
// pipelined write->read, error responses, BUSY beats and mid-transfer reset.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

  localparam int MEM_BYTES = 4096;
`ifdef AHB_SLV_WAITSTATE_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dbg_state;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  ahb_sram_slave_if bus ();

  // Single slave on the bus: its hreadyout is the bus hready.
  assign bus.hready = bus.hreadyout;

  ahb_sram_slave #(
    .MEM_BYTES   (MEM_BYTES),
    .WAIT_CYCLES (2)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic bus_idle();
    bus.hsel      = 1'b0;
    bus.htrans    = 2'b00;
    bus.haddr     = 32'd0;
    bus.hwrite    = 1'b0;
    bus.hsize     = 3'd0;
    bus.hburst    = 3'd0;
    bus.hprot     = 4'd0;
    bus.hmastlock = 1'b0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [2:0] sz,
                            input logic wr);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.haddr  = a;
    bus.hsize  = sz;
    bus.hwrite = wr;
  endtask

  // Samples each data-phase cycle at the falling edge until hreadyout=1.
  task automatic wait_ready(output int waits, output logic first_resp,
                            output logic last_resp, output logic [31:0] rdata);
    waits      = 0;
    first_resp = 1'b0;
    last_resp  = 1'b0;
    rdata      = 32'd0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c == 0) first_resp = bus.hresp;
      if (bus.hreadyout) begin
        last_resp = bus.hresp;
        rdata     = bus.hrdata;
        return;
      end
      waits++;
      if (!bus.hresp) check("wait_rdata_zero", bus.hrdata, 32'd0);
    end
    check("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wdata, output int waits,
                      output logic first_resp, output logic last_resp,
                      output logic [31:0] rdata);
    @(posedge clk); #1;
    addr_phase(a, sz, wr);
    @(posedge clk); #1;
    bus_idle();
    bus.hwdata = wdata;
    wait_ready(waits, first_resp, last_resp, rdata);
  endtask

  task automatic write_ok(input string tag, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] d);
    int waits; logic fr, lr; logic [31:0] rd;
    xfer(1'b1, a, sz, d, waits, fr, lr, rd);
    check({tag, "_resp"}, 32'(lr), 32'd0);
    check({tag, "_waits"}, 32'(waits), 32'(EXP_WAIT));
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] exp);
    int waits; logic fr, lr; logic [31:0] rd;
    exp_q.push_back(exp);
    xfer(1'b0, a, sz, 32'd0, waits, fr, lr, rd);
    check({tag, "_resp"}, 32'(lr), 32'd0);
    check({tag, "_waits"}, 32'(waits), 32'(EXP_WAIT));
    check({tag, "_rdata"}, rd, exp_q.pop_front());
  endtask

  task automatic err_chk(input string tag, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz);
    int waits; logic fr, lr; logic [31:0] rd;
    xfer(wr, a, sz, 32'hFFFF_FFFF, waits, fr, lr, rd);
    check({tag, "_resp1"}, 32'(fr), 32'd1);
    check({tag, "_resp2"}, 32'(lr), 32'd1);
    check({tag, "_cycles"}, 32'(waits), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waits; logic fr, lr; logic [31:0] rd;

    rst = 1'b1;
    bus_idle();
    bus.hwdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    check("rst_hresp", 32'(bus.hresp), 32'd0);
    check("rst_hrdata", bus.hrdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // word write then read
    write_ok("w10", 32'h10, 3'd2, 32'hDEAD_BEEF);
    read_chk("r10", 32'h10, 3'd2, 32'hDEAD_BEEF);

    // byte and halfword lane merging
    write_ok("w10b", 32'h10, 3'd2, 32'h1122_3344);
    write_ok("wb13", 32'h13, 3'd0, 32'hA500_0000);
    read_chk("r10b", 32'h10, 3'd2, 32'hA522_3344);
    read_chk("r13byte", 32'h13, 3'd0, 32'hA522_3344);
    write_ok("w14", 32'h14, 3'd2, 32'h5566_7788);
    write_ok("wh16", 32'h16, 3'd1, 32'hCAFE_0000);
    write_ok("wb15", 32'h15, 3'd0, 32'h0000_9900);
    read_chk("r14", 32'h14, 3'd2, 32'hCAFE_9988);

    // pipelined write -> read of the same word
    @(posedge clk); #1;
    addr_phase(32'h20, 3'd2, 1'b1);
    @(posedge clk); #1;
    addr_phase(32'h20, 3'd2, 1'b0);
    bus.hwdata = 32'h0BAD_F00D;
    wait_ready(waits, fr, lr, rd);
    check("pipe_w_resp", 32'(lr), 32'd0);
    check("pipe_w_waits", 32'(waits), 32'(EXP_WAIT));
    @(posedge clk); #1;
    bus_idle();
    bus.hwdata = 32'd0;
    wait_ready(waits, fr, lr, rd);
    check("pipe_r_resp", 32'(lr), 32'd0);
    check("pipe_r_waits", 32'(waits), 32'(EXP_WAIT));
    check("pipe_r_rdata", rd, 32'h0BAD_F00D);

    // error responses; none of them may touch word 0x20
    err_chk("e_oor", 1'b0, 32'h0000_1000, 3'd2);
    err_chk("e_half", 1'b1, 32'h21, 3'd1);
    err_chk("e_size", 1'b0, 32'h0, 3'd3);
    err_chk("e_word", 1'b1, 32'h22, 3'd2);
    read_chk("r20_post_err", 32'h20, 3'd2, 32'h0BAD_F00D);

    // BUSY beat: zero-wait OKAY, not accepted
    @(posedge clk); #1;
    bus.hsel   = 1'b1;
    bus.htrans = 2'b01;
    @(negedge clk);
    check("busy_ready", 32'(bus.hreadyout), 32'd1);
    check("busy_resp", 32'(bus.hresp), 32'd0);
    @(negedge clk);
    check("busy_state", 32'(dbg_state), 32'd0);
    bus_idle();

    // reset during a write data phase
    write_ok("w30", 32'h30, 3'd2, 32'h1234_5678);
    @(posedge clk); #1;
    addr_phase(32'h30, 3'd2, 1'b1);
    @(posedge clk); #1;
    bus_idle();
    bus.hwdata = 32'hFFFF_FFFF;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.hreadyout), 32'd1);
    check("mid_rst_resp", 32'(bus.hresp), 32'd0);
    check("mid_rst_rdata", bus.hrdata, 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.hwdata = 32'd0;
    read_chk("r30_post_rst", 32'h30, 3'd2, 32'h1234_5678);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
